// File: rtl/ber_checker_if.sv
// Receiver-side bit stream into the BER checker and its status/counter outputs.
interface ber_checker_if #(
  parameter int CNT_W = 32
);
  logic             bit_valid;
  logic             data_i;
  logic             clear;
  logic             locked;
  logic             err_o;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output bit_valid, data_i, clear,
    input  locked, err_o, bit_count, err_count
  );

  modport slave (
    input  bit_valid, data_i, clear,
    output locked, err_o, bit_count, err_count
  );
endinterface

// File: rtl/ber_checker.sv
// PN-sequence bit-error-rate checker: self-synchronising acquisition,
// flywheel prediction once locked, saturating bit/error counters.
//
// state  | meaning
// SEARCH | filling the PN register with received bits
// VERIFY | self-synchronised compare, counting consecutive matches
// LOCKED | flywheel compare, counting bits/errors, watching for loss of lock
module ber_checker #(
  parameter int             N           = 7,
  parameter logic [N-1:0]   TAPS        = 7'b1100000,
  parameter int             LOCK_THRESH = 16,
  parameter int             WINDOW      = 64,
  parameter int             LOSS_THRESH = 8,
  parameter int             CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  ber_checker_if.slave    bus
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [N-1:0]       s_q,         s_d;
  logic [FILL_W-1:0]  fill_q,      fill_d;
  logic [MATCH_W-1:0] match_q,     match_d;
  logic [WIN_W-1:0]   win_q,       win_d;
  logic [WERR_W-1:0]  werr_q,      werr_d;
  logic               locked_q,    locked_d;
  logic               err_o_q,     err_o_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  // Next-state, PN register, window tracking and counter updates.
  always_comb begin
    logic               p;
    logic               miss;
    logic [N-1:0]       shift_rx;
    logic [N-1:0]       shift_fly;
    logic [MATCH_W-1:0] match_nxt;
    logic [WIN_W-1:0]   win_nxt;
    logic [WERR_W-1:0]  werr_nxt;
    logic               bit_inc;
    logic               err_inc;

    p         = ^(s_q & TAPS);
    miss      = bus.data_i ^ p;
    shift_rx  = {s_q[N-2:0], bus.data_i};
    shift_fly = {s_q[N-2:0], p};
    match_nxt = '0;
    win_nxt   = '0;
    werr_nxt  = '0;
    bit_inc   = 1'b0;
    err_inc   = 1'b0;

    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;

    if (bus.bit_valid) begin
      unique case (state_q)
        SEARCH: begin
          s_d = shift_rx;
          if (fill_q == FILL_W'(N - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          s_d       = shift_rx;
          match_nxt = miss ? '0 : match_q + MATCH_W'(1);
          match_d   = match_nxt;
          // An all-zero register would predict zeros forever; restart acquisition.
          if (shift_rx == '0) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
          end else if (match_nxt == MATCH_W'(LOCK_THRESH)) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the register follows its own prediction, not the line.
          s_d      = shift_fly;
          bit_inc  = 1'b1;
          err_inc  = miss;
          werr_nxt = werr_q + WERR_W'(miss);
          win_nxt  = win_q + WIN_W'(1);
          if (werr_nxt == WERR_W'(LOSS_THRESH)) begin
            state_d = SEARCH;
            fill_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_nxt == WIN_W'(WINDOW)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_nxt;
            werr_d = werr_nxt;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end

    // Clear takes precedence over a coincident count; that bit goes uncounted.
    if (bus.clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end else begin
      if (bit_inc && (bit_count_q != '1)) bit_count_d = bit_count_q + CNT_W'(1);
      if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    end

    err_o_d  = err_inc & ~bus.clear;
    locked_d = (state_d == LOCKED);
  end

  // Register all state and outputs; asynchronous reset to the SEARCH state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      locked_q    <= 1'b0;
      err_o_q     <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      locked_q    <= locked_d;
      err_o_q     <= err_o_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_o     = err_o_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;

endmodule
